lbm_step_sequencer: RTL and testbench
=====================================

// Module: lbm_step_sequencer
// PURPOSE
// Top-level time-step scheduler for the LBM solver. For each simulation time step it walks
// every lattice node through three phases in order: COLLIDE, STREAM, BOUNDARY.
// It issues one node address per transfer to the node datapath over a valid/ready handshake.
// It pulses a step-complete strobe per step and stops after MAX_TIME steps.
// PARAMETERS
// MAX_TIME          8                   number of time steps per run (>=2)
// TIME_COUNT_WIDTH  $clog2(MAX_TIME)    width of time_step
// NUM_NODES         64                  lattice nodes per phase (>=2)
// ADDR_WIDTH        $clog2(NUM_NODES)   width of node_addr
// PORTS
// Clk         in   1                 system clock, all logic on rising edge
// Reset       in   1                 synchronous, active-high reset
// Start       in   1                 level; sampled only in IDLE, begins a run
// Abort       in   1                 level; synchronous return to IDLE from any state
// node_ready  in   1                 datapath accepts current node this cycle
// node_valid  out  1                 node_addr/phase valid for datapath
// node_addr   out  ADDR_WIDTH        lattice node index being issued
// phase       out  2                 0=COLLIDE 1=STREAM 2=BOUNDARY (3 unused)
// time_step   out  TIME_COUNT_WIDTH  index of current step, 0..MAX_TIME-1
// step_done   out  1                 1-cycle pulse when a step's BOUNDARY phase completes
// busy        out  1                 high in COLLIDE/STREAM/BOUNDARY/STEP_END
// sim_done    out  1                 high in DONE
// BEHAVIOUR
// - States: IDLE, COLLIDE, STREAM, BOUNDARY, STEP_END, DONE. Outputs decode from registered state/counters.
// - Reset (or Abort): state=IDLE, node_addr=0, time_step=0, phase=0, all 1-bit outputs 0.
// - Reset has priority over Abort, and Abort has priority over all other transitions.
// - Abort does not pulse step_done.
// - IDLE: if Start=1 at edge k, go to COLLIDE with node_addr=0 and time_step=0.
//   node_valid=1 from cycle k+1.
// - Phase states: node_valid=1, phase=state encoding.
//   A transfer occurs on an edge where node_valid&&node_ready.
//   - node_addr and phase are held stable while node_ready=0.
//   - On a transfer with node_addr<NUM_NODES-1: node_addr+1.
//   - On a transfer with node_addr==NUM_NODES-1: node_addr=0 and advance
//     COLLIDE->STREAM->BOUNDARY->STEP_END. No idle cycle between phases.
// - STEP_END (one cycle): node_valid=0, step_done=1.
//   - If time_step==MAX_TIME-1, go to DONE; time_step holds MAX_TIME-1.
//   - Otherwise time_step+1 and go to COLLIDE.
// - DONE: sim_done=1, busy=0, node_valid=0. Stays in DONE while Start=1; goes to IDLE when Start=0.
//   A new run therefore needs Start low then high again.
// - Start is ignored outside IDLE and DONE.
// - With node_ready tied high: a step takes 3*NUM_NODES+1 cycles, and a run keeps busy high
//   for MAX_TIME*(3*NUM_NODES+1) cycles.
// - No wrap of time_step: it never exceeds MAX_TIME-1.
// - node_addr never exceeds NUM_NODES-1, and phase never shows 3.
// TESTING (bench overrides NUM_NODES=4, MAX_TIME=8)
// 1 Reset high 2 cycles, release -> all outputs 0, state IDLE; Start=0 keeps node_valid=0.
// 2 Start pulse, node_ready=1 -> per step:
//   - addr 0..3 with phase 0, then 0..3 with phase 1, then 0..3 with phase 2, then 1 gap cycle.
//   - step_done pulses every 13 cycles.
//   - After 8 pulses: time_step=7, sim_done=1; busy was high exactly 104 cycles.
// 3 node_ready low 3 cycles at STREAM addr 2 -> node_addr=2 and phase=1 held.
//   Step length grows to 16 cycles.
// 4 Abort at time_step=3, BOUNDARY addr 1 -> next cycle IDLE, time_step=0, no step_done pulse.
//   Restart runs a full 8 steps.
// 5 Reset asserted mid-COLLIDE of step 5 -> identical to Abort result. Start held high through DONE:
//   - Stays in DONE with sim_done=1.
//   - Start low -> IDLE. Start high -> new run from time_step=0.

Source files
------------

// File: rtl/lbm_step_sequencer.sv
// Time-step scheduler for the LBM solver: walks every lattice node through
// COLLIDE, STREAM and BOUNDARY per step, for MAX_TIME steps per run.
module lbm_step_sequencer #(
    parameter int MAX_TIME         = 8,
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
    parameter int NUM_NODES        = 64,
    parameter int ADDR_WIDTH       = $clog2(NUM_NODES)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic                        Abort,
    input  logic                        node_ready,
    output logic                        node_valid,
    output logic [ADDR_WIDTH-1:0]       node_addr,
    output logic [1:0]                  phase,
    output logic [TIME_COUNT_WIDTH-1:0] time_step,
    output logic                        step_done,
    output logic                        busy,
    output logic                        sim_done
);

    typedef enum logic [2:0] {
        IDLE,
        COLLIDE,
        STREAM,
        BOUNDARY,
        STEP_END,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]       LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);
    localparam logic [TIME_COUNT_WIDTH-1:0] LAST_STEP = TIME_COUNT_WIDTH'(MAX_TIME - 1);

    state_t                        state, state_nx;
    logic [ADDR_WIDTH-1:0]         addr_nx;
    logic [TIME_COUNT_WIDTH-1:0]   step_nx;
    logic                          xfer;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            node_addr <= '0;
            time_step <= '0;
        end else begin
            state     <= state_nx;
            node_addr <= addr_nx;
            time_step <= step_nx;
        end
    end

    assign xfer = node_valid && node_ready;

    always_comb begin
        state_nx = state;
        addr_nx  = node_addr;
        step_nx  = time_step;
        if (Abort) begin
            state_nx = IDLE;
            addr_nx  = '0;
            step_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state_nx = COLLIDE;
                        addr_nx  = '0;
                        step_nx  = '0;
                    end
                end
                COLLIDE, STREAM, BOUNDARY: begin
                    if (xfer) begin
                        if (node_addr == LAST_ADDR) begin
                            // Phase ends on the last node's transfer; next phase starts immediately.
                            addr_nx = '0;
                            case (state)
                                COLLIDE: state_nx = STREAM;
                                STREAM:  state_nx = BOUNDARY;
                                default: state_nx = STEP_END;
                            endcase
                        end else begin
                            addr_nx = node_addr + 1'b1;
                        end
                    end
                end
                STEP_END: begin
                    if (time_step == LAST_STEP) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = COLLIDE;
                        step_nx  = time_step + 1'b1;
                    end
                end
                DONE: begin
                    // Start must drop before a new run can begin.
                    if (!Start) begin
                        state_nx = IDLE;
                        step_nx  = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                    step_nx  = '0;
                end
            endcase
        end
    end

    always_comb begin
        node_valid = 1'b0;
        phase      = 2'd0;
        step_done  = 1'b0;
        busy       = 1'b0;
        sim_done   = 1'b0;
        case (state)
            COLLIDE: begin
                node_valid = 1'b1;
                phase      = 2'd0;
                busy       = 1'b1;
            end
            STREAM: begin
                node_valid = 1'b1;
                phase      = 2'd1;
                busy       = 1'b1;
            end
            BOUNDARY: begin
                node_valid = 1'b1;
                phase      = 2'd2;
                busy       = 1'b1;
            end
            STEP_END: begin
                step_done  = 1'b1;
                busy       = 1'b1;
            end
            DONE:    sim_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (node_addr <= LAST_ADDR);
            assert (time_step <= LAST_STEP);
            assert (phase != 2'd3);
        end
    end

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Randomized and directed bench for lbm_step_sequencer, checked against a
// slot-index model of a run (NUM_NODES=4, MAX_TIME=8).
module tb_lbm_step_sequencer;

    localparam int N     = 4;
    localparam int MT    = 8;
    localparam int AW    = $clog2(N);
    localparam int TW    = $clog2(MT);
    localparam int SLOTS = 3 * N + 1;
    localparam int OW    = 1 + AW + 2 + TW + 3;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic          node_ready = 1'b0;
    logic          node_valid;
    logic [AW-1:0] node_addr;
    logic [1:0]    phase;
    logic [TW-1:0] time_step;
    logic          step_done;
    logic          busy;
    logic          sim_done;

    int n_total = 0;
    int n_pass  = 0;

    // Model: 0=idle, 1=running at slot m_pos of the flattened run, 2=done.
    int m_mode = 0;
    int m_pos  = 0;

    logic [OW-1:0] obs, exp_v;
    assign obs = {node_valid, node_addr, phase, time_step, step_done, busy, sim_done};

    lbm_step_sequencer #(.MAX_TIME(MT), .NUM_NODES(N)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .node_ready(node_ready), .node_valid(node_valid), .node_addr(node_addr),
        .phase(phase), .time_step(time_step), .step_done(step_done),
        .busy(busy), .sim_done(sim_done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [OW-1:0] model_out();
        logic [OW-1:0] v;
        int s, r;
        v = '0;
        if (m_mode == 1) begin
            s = m_pos / SLOTS;
            r = m_pos % SLOTS;
            if (r < 3 * N) v = {1'b1, AW'(r % N), 2'(r / N), TW'(s), 3'b010};
            else           v = {1'b0, {AW{1'b0}}, 2'b00, TW'(s), 3'b110};
        end else if (m_mode == 2) begin
            v = {1'b0, {AW{1'b0}}, 2'b00, TW'(MT - 1), 3'b001};
        end
        return v;
    endfunction

    task automatic model_update();
        if (Reset || Abort) begin
            m_mode = 0;
            m_pos  = 0;
        end else begin
            case (m_mode)
                0: if (Start) begin m_mode = 1; m_pos = 0; end
                1: begin
                    if (m_pos % SLOTS == 3 * N) begin
                        if (m_pos == MT * SLOTS - 1) m_mode = 2;
                        else m_pos++;
                    end else if (node_ready) begin
                        m_pos++;
                    end
                end
                default: if (!Start) m_mode = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_update();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; node_ready = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        tick();
        n_total++;
        if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = model_out();
            n_total++;
            if (node_valid !== 1'b0 || obs !== exp_v)
                $display("FAIL idle_hold: got %h expected %h", obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_full_run();
        int busy_cnt, pulses, bad_iv, last_p, cyc;
        bit fin;
        busy_cnt = 0; pulses = 0; bad_iv = 0; last_p = -1; cyc = 0; fin = 0;
        node_ready = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            exp_v = model_out();
            n_total++;
            if (obs !== exp_v) $display("FAIL run_trace: got %h expected %h", obs, exp_v);
            else n_pass++;
            if (busy) busy_cnt++;
            if (step_done) begin
                if (last_p >= 0 && cyc - last_p != 13) bad_iv++;
                last_p = cyc;
                pulses++;
            end
            if (sim_done) fin = 1;
            else begin tick(); cyc++; end
        end
        n_total++;
        if (!fin) $display("FAIL run_timeout: sim_done never rose");
        else n_pass++;
        n_total++;
        if (pulses != 8) $display("FAIL run_pulses: got %0d expected 8", pulses);
        else n_pass++;
        n_total++;
        if (busy_cnt != 104) $display("FAIL run_busy: got %0d expected 104", busy_cnt);
        else n_pass++;
        n_total++;
        if (bad_iv != 0) $display("FAIL run_period: got %0d bad intervals expected 0", bad_iv);
        else n_pass++;
        n_total++;
        if (time_step !== TW'(MT - 1) || sim_done !== 1'b1)
            $display("FAIL run_end: got ts=%0d sim_done=%b expected ts=7 sim_done=1", time_step, sim_done);
        else n_pass++;
        tick();
        n_total++;
        if (obs !== '0) $display("FAIL done_to_idle: got %h expected 0", obs);
        else n_pass++;
    endtask

    task automatic test_stall();
        int p[$];
        int cyc, stall_left, hold_bad;
        bit fin, stalled;
        cyc = 0; stall_left = 0; hold_bad = 0; fin = 0; stalled = 0;
        node_ready = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 300 && !fin; i++) begin
            exp_v = model_out();
            n_total++;
            if (obs !== exp_v) $display("FAIL stall_trace: got %h expected %h", obs, exp_v);
            else n_pass++;
            if (stall_left > 0 && (node_addr !== AW'(2) || phase !== 2'd1)) hold_bad++;
            if (step_done) p.push_back(cyc);
            if (sim_done) fin = 1;
            else begin
                if (!stalled && node_valid && time_step == TW'(1) && phase == 2'd1 && node_addr == AW'(2)) begin
                    stalled = 1;
                    stall_left = 3;
                end
                node_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                tick();
                cyc++;
            end
        end
        node_ready = 1'b1;
        n_total++;
        if (!fin || !stalled || p.size() != 8)
            $display("FAIL stall_run: got fin=%0d stalled=%0d pulses=%0d expected 1 1 8", fin, stalled, p.size());
        else n_pass++;
        n_total++;
        if (hold_bad != 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", hold_bad);
        else n_pass++;
        if (p.size() >= 3) begin
            n_total++;
            if (p[1] - p[0] != 16) $display("FAIL stall_step_len: got %0d expected 16", p[1] - p[0]);
            else n_pass++;
            n_total++;
            if (p[2] - p[1] != 13) $display("FAIL stall_next_len: got %0d expected 13", p[2] - p[1]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_abort();
        bit found, fin;
        int pulses;
        found = 0; fin = 0; pulses = 0;
        node_ready = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (node_valid && time_step == TW'(3) && phase == 2'd2 && node_addr == AW'(1)) found = 1;
            else tick();
        end
        n_total++;
        if (!found) $display("FAIL abort_reach: target point never observed");
        else n_pass++;
        Abort = 1'b1; tick(); Abort = 1'b0;
        n_total++;
        if (obs !== '0) $display("FAIL abort_idle: got %h expected 0", obs);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (step_done !== 1'b0 || obs !== model_out())
                $display("FAIL abort_quiet: got %h expected %h", obs, model_out());
            else n_pass++;
        end
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            exp_v = model_out();
            n_total++;
            if (obs !== exp_v) $display("FAIL restart_trace: got %h expected %h", obs, exp_v);
            else n_pass++;
            if (step_done) pulses++;
            if (sim_done) fin = 1;
            else tick();
        end
        n_total++;
        if (!fin || pulses != 8) $display("FAIL restart_run: got fin=%0d pulses=%0d expected 1 8", fin, pulses);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        bit found, fin;
        found = 0; fin = 0;
        node_ready = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 120 && !found; i++) begin
            if (node_valid && time_step == TW'(5) && phase == 2'd0 && node_addr == AW'(2)) found = 1;
            else tick();
        end
        n_total++;
        if (!found) $display("FAIL rst_reach: target point never observed");
        else n_pass++;
        Reset = 1'b1; tick(); Reset = 1'b0;
        n_total++;
        if (obs !== '0) $display("FAIL rst_mid_idle: got %h expected 0", obs);
        else n_pass++;
        Start = 1'b1;
        for (int i = 0; i < 200 && !fin; i++) begin
            tick();
            exp_v = model_out();
            n_total++;
            if (obs !== exp_v) $display("FAIL held_start_trace: got %h expected %h", obs, exp_v);
            else n_pass++;
            if (sim_done) fin = 1;
        end
        n_total++;
        if (!fin) $display("FAIL held_start_timeout: sim_done never rose");
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (sim_done !== 1'b1 || busy !== 1'b0 || obs !== model_out())
                $display("FAIL done_hold: got %h expected %h", obs, model_out());
            else n_pass++;
        end
        Start = 1'b0; tick();
        n_total++;
        if (obs !== '0) $display("FAIL done_release: got %h expected 0", obs);
        else n_pass++;
        Start = 1'b1; tick(); Start = 1'b0;
        n_total++;
        if (node_valid !== 1'b1 || time_step !== '0 || node_addr !== '0 || obs !== model_out())
            $display("FAIL new_run: got %h expected %h", obs, model_out());
        else n_pass++;
        Abort = 1'b1; tick(); Abort = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            node_ready = ($urandom_range(0, 3) != 0);
            Start      = ($urandom_range(0, 7) == 0);
            Abort      = ($urandom_range(0, 299) == 0);
            tick();
            exp_v = model_out();
            n_total++;
            if (obs !== exp_v) $display("FAIL random_trace: cycle %0d got %h expected %h", i, obs, exp_v);
            else n_pass++;
        end
        Start = 1'b0; Abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
